mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL take parameter ADDR_W, default 10, SRAM word-address width.
REQ-002 SHALL take parameter STARVE_MAX, default 4, max consecutive D grants while I waits.
REQ-003 SHALL have port CLK  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port RSTN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port IREQ  input  1  instruction-read request, held until I_GNT.
REQ-006 SHALL have port IADDR  input  30  instruction byte-style address; word index = IADDR[ADDR_W+1:2].
REQ-007 SHALL have port DREQ  input  1  data request, held until D_GNT.
REQ-008 SHALL have port DRW  input  1  1 = write, 0 = read.
REQ-009 SHALL have port DADDR  input  30  data address; word index = DADDR[ADDR_W+1:2].
REQ-010 SHALL have port DWDATA  input  32  write data.
REQ-011 SHALL have ports I_GNT, D_GNT  output  1 each  one-cycle grant pulses.
REQ-012 SHALL have ports I_RVALID, D_RVALID  output  1 each  read-return pulses.
REQ-013 SHALL have ports INSTR, DRDATA  output  32 each  held read-return data.
REQ-014 SHALL have port STALL  output  1  a request is pending and not granted this cycle.
REQ-015 SHALL have SRAM ports CSN (out, 1, active-low select), WEN (out, 1, 0 = write), A (out, ADDR_W), DI (out, 32), DOUT (in, 32, valid cycle after a CSN-low read).

Function
REQ-016 SHALL grant at most one requester per cycle; I_GNT and D_GNT never both 1.
REQ-017 SHALL assert the grant combinationally in the cycle the SRAM is driven: CSN=0, A/WEN/DI from the winner.
REQ-018 SHALL give DREQ priority over IREQ, except when starve counter = STARVE_MAX and IREQ=1, then I wins.
REQ-019 SHALL increment starve counter on each D grant while IREQ=1, clear it on any I grant or when IREQ=0, saturate at STARVE_MAX.
REQ-020 SHALL drive CSN=1, WEN=1, A=0, DI=0 when no request is pending.
REQ-021 SHALL drive WEN=0, DI=DWDATA on a D grant with DRW=1; WEN=1 on all reads.
REQ-022 SHALL register a return-select tag (NONE, I, D) at each grant; write grants record NONE.
REQ-023 SHALL, in the cycle after a read grant, pulse the tagged RVALID for one cycle and load DOUT into INSTR or DRDATA.
REQ-024 SHALL hold INSTR and DRDATA unchanged between their own returns (other port's traffic does not disturb them).
REQ-025 SHALL compute STALL = (IREQ & ~I_GNT) | (DREQ & ~D_GNT).
REQ-026 SHALL sustain back-to-back grants every cycle; read latency grant-to-RVALID is exactly 1 cycle.
REQ-027 SHALL allow a return and a new grant in the same cycle with no loss.
REQ-028 SHALL treat address bits above ADDR_W+1 as don't-care (wrap within SRAM).

Reset
REQ-029 SHALL on RSTN=0 immediately clear: return tag to NONE, starve counter to 0, INSTR=0, DRDATA=0, I_RVALID=D_RVALID=0.
REQ-030 SHALL gate grants and drive CSN=1 while RSTN=0 regardless of requests.
REQ-031 SHALL drop any outstanding read return when reset asserts mid-operation; no RVALID after release for pre-reset grants.

Verification
REQ-032 SHALL pass: IREQ only, IADDR=0x8, M[2]=0x12345678 -> I_GNT cycle 0, A=2, I_RVALID cycle 1, INSTR=0x12345678, STALL=0.
REQ-033 SHALL pass: IREQ and DREQ read same cycle -> D_GNT first, STALL=1, I_GNT next cycle, DRDATA then INSTR each 1 cycle after grant.
REQ-034 SHALL pass: DREQ write DADDR=0x10, DWDATA=0xCAFEF00D, then read 0x10 -> WEN=0, A=4, no D_RVALID for write; read returns 0xCAFEF00D.
REQ-035 SHALL pass: DREQ and IREQ held continuously, STARVE_MAX=4 -> pattern D,D,D,D,I repeating; never 5 consecutive D grants.
REQ-036 SHALL pass: RSTN low in cycle after I read grant -> no I_RVALID, INSTR=0, CSN=1 during reset.
REQ-037 SHALL pass: alternating I/D reads every cycle -> INSTR unchanged across D returns and vice versa.

Source files
------------

// File: rtl/mem_arbiter.sv
// Instruction/data arbiter onto one single-port SRAM; data wins unless instruction has waited STARVE_MAX grants.
// Grant is combinational with the SRAM strobe, read data returns exactly one cycle later; losers stall and hold.
module mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              IREQ,
  input  logic [29:0]       IADDR,
  input  logic              DREQ,
  input  logic              DRW,
  input  logic [29:0]       DADDR,
  input  logic [31:0]       DWDATA,
  output logic              I_GNT,
  output logic              D_GNT,
  output logic              I_RVALID,
  output logic              D_RVALID,
  output logic [31:0]       INSTR,
  output logic [31:0]       DRDATA,
  output logic              STALL,
  output logic              CSN,
  output logic              WEN,
  output logic [ADDR_W-1:0] A,
  output logic [31:0]       DI,
  input  logic [31:0]       DOUT
);

  localparam int               CNT_W    = $clog2(STARVE_MAX + 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_MAX);
  localparam logic [1:0]       TAG_NONE = 2'd0;
  localparam logic [1:0]       TAG_I    = 2'd1;
  localparam logic [1:0]       TAG_D    = 2'd2;

  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [1:0]        tag_q, tag_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       drdata_q, drdata_d;
  logic              i_win, i_gnt, d_gnt, d_wr;
  logic [ADDR_W-1:0] i_word, d_word;
  logic              unused_addr_bits;

  // Address bits outside the word index wrap within the SRAM.
  assign i_word           = IADDR[ADDR_W+1:2];
  assign d_word           = DADDR[ADDR_W+1:2];
  assign unused_addr_bits = ^{IADDR[29:ADDR_W+2], IADDR[1:0], DADDR[29:ADDR_W+2], DADDR[1:0]};

  always_comb begin
    i_win = IREQ & (~DREQ | (starve_q == CNT_MAX));
    i_gnt = RSTN & i_win;
    d_gnt = RSTN & DREQ & ~i_win;
    d_wr  = d_gnt & DRW;

    I_GNT = i_gnt;
    D_GNT = d_gnt;
    STALL = (IREQ & ~i_gnt) | (DREQ & ~d_gnt);
    CSN   = ~(i_gnt | d_gnt);
    WEN   = ~d_wr;
    DI    = d_wr ? DWDATA : 32'h0;
    A     = i_gnt ? i_word : (d_gnt ? d_word : '0);
  end

  // Return path: the tag captured at grant steers next cycle's DOUT to its port.
  always_comb begin
    I_RVALID = (tag_q == TAG_I);
    D_RVALID = (tag_q == TAG_D);
    INSTR    = I_RVALID ? DOUT : instr_q;
    DRDATA   = D_RVALID ? DOUT : drdata_q;
    instr_d  = INSTR;
    drdata_d = DRDATA;

    tag_d = TAG_NONE;
    if (i_gnt) begin
      tag_d = TAG_I;
    end else if (d_gnt && !DRW) begin
      tag_d = TAG_D;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!IREQ || i_gnt) begin
      starve_d = '0;
    end else if (d_gnt && (starve_q != CNT_MAX)) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      starve_q <= '0;
      tag_q    <= TAG_NONE;
      instr_q  <= 32'h0;
      drdata_q <= 32'h0;
    end else begin
      starve_q <= starve_d;
      tag_q    <= tag_d;
      instr_q  <= instr_d;
      drdata_q <= drdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural SRAM, directed scenarios and random traffic against a cycle model.
module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int SM = 4;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          IREQ = 1'b0;
  logic [29:0]   IADDR = '0;
  logic          DREQ = 1'b0;
  logic          DRW = 1'b0;
  logic [29:0]   DADDR = '0;
  logic [31:0]   DWDATA = '0;
  logic          I_GNT, D_GNT, I_RVALID, D_RVALID, STALL, CSN, WEN;
  logic [31:0]   INSTR, DRDATA, DI;
  logic [AW-1:0] A;
  logic [31:0]   DOUT;

  mem_arbiter #(.ADDR_W(AW), .STARVE_MAX(SM)) dut (
    .CLK(CLK), .RSTN(RSTN), .IREQ(IREQ), .IADDR(IADDR), .DREQ(DREQ), .DRW(DRW),
    .DADDR(DADDR), .DWDATA(DWDATA), .I_GNT(I_GNT), .D_GNT(D_GNT),
    .I_RVALID(I_RVALID), .D_RVALID(D_RVALID), .INSTR(INSTR), .DRDATA(DRDATA),
    .STALL(STALL), .CSN(CSN), .WEN(WEN), .A(A), .DI(DI), .DOUT(DOUT)
  );

  always #5 CLK = ~CLK;

  logic [31:0] sram [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (!CSN) begin
      if (!WEN) sram[A] <= DI;
      else      DOUT    <= sram[A];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:(1<<AW)-1];
  int          starve = 0;
  int          ret_kind = 0;   // 0 none, 1 instruction, 2 data
  logic [31:0] ret_data = '0;
  logic [31:0] exp_instr = '0;
  logic [31:0] exp_drdata = '0;
  int          d_run = 0;
  int          i_gnt_seen = 0;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [29:0] rand_addr();
    logic [29:0] a;
    a = 30'($urandom);
    a[AW+1:2] = AW'($urandom_range(0, 15));
    return a;
  endfunction

  // One clock: check combinational outputs mid-cycle, advance model, retire granted requests.
  task automatic step();
    bit            ei, ed;
    logic [AW-1:0] iw, dw, ea;
    @(negedge CLK); #1;
    iw = IADDR[AW+1:2];
    dw = DADDR[AW+1:2];
    ei = RSTN && IREQ && (!DREQ || starve == SM);
    ed = RSTN && DREQ && !ei;
    ea = ei ? iw : (ed ? dw : '0);
    if (!RSTN) begin
      ret_kind = 0; exp_instr = '0; exp_drdata = '0; starve = 0;
    end
    chk("i_gnt", I_GNT, ei);
    chk("d_gnt", D_GNT, ed);
    chk("one_hot", I_GNT & D_GNT, 0);
    chk("csn", CSN, !(ei || ed));
    chk("wen", WEN, !(ed && DRW));
    chk("addr", A, ea);
    chk("di", DI, (ed && DRW) ? DWDATA : 32'h0);
    chk("stall", STALL, (IREQ && !ei) || (DREQ && !ed));
    if (ret_kind == 1) exp_instr = ret_data;
    if (ret_kind == 2) exp_drdata = ret_data;
    chk("i_rvalid", I_RVALID, ret_kind == 1);
    chk("d_rvalid", D_RVALID, ret_kind == 2);
    chk("instr", INSTR, exp_instr);
    chk("drdata", DRDATA, exp_drdata);
    if (I_GNT) i_gnt_seen++;

    ret_kind = 0;
    if (ei) begin
      ret_kind = 1;
      ret_data = ref_mem[iw];
    end
    if (ed) begin
      if (DRW) ref_mem[dw] = DWDATA;
      else begin
        ret_kind = 2;
        ret_data = ref_mem[dw];
      end
    end
    if (!IREQ || ei) starve = 0;
    else if (ed && starve < SM) starve++;
    if (ed && IREQ) d_run++;
    else d_run = 0;
    chk("starve_bound", d_run <= SM, 1);

    @(posedge CLK); #1;
    if (ei) IREQ = 1'b0;
    if (ed) DREQ = 1'b0;
  endtask

  task automatic reset_pulse();
    RSTN = 1'b0;
    #1;
    chk("rst_i_rvalid", I_RVALID, 0);
    chk("rst_d_rvalid", D_RVALID, 0);
    chk("rst_instr", INSTR, 0);
    chk("rst_drdata", DRDATA, 0);
    chk("rst_csn", CSN, 1);
    ret_kind = 0; exp_instr = '0; exp_drdata = '0; starve = 0; d_run = 0;
    step();
    step();
    RSTN = 1'b1;
  endtask

  task automatic drive_random();
    if (!IREQ) begin
      IADDR = rand_addr();
      IREQ  = ($urandom_range(0, 2) != 0);
    end
    if (!DREQ) begin
      DADDR  = rand_addr();
      DRW    = 1'($urandom_range(0, 1));
      DWDATA = $urandom;
      DREQ   = ($urandom_range(0, 2) != 0);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      sram[i]    = $urandom;
      ref_mem[i] = sram[i];
    end
    sram[2]    = 32'h1234_5678;
    ref_mem[2] = 32'h1234_5678;

    // Reset state with a request pending: grants gated, outputs cleared.
    IREQ = 1'b1; IADDR = 30'h8;
    step();
    step();
    RSTN = 1'b1;

    // Single instruction read of word 2.
    step();
    step();
    chk("i_read_data", INSTR, 32'h1234_5678);

    // Simultaneous reads: data first, instruction next.
    IREQ = 1'b1; IADDR = 30'h8; DREQ = 1'b1; DRW = 1'b0; DADDR = 30'h1C;
    repeat (3) step();

    // Data write then read-back of the same word.
    DREQ = 1'b1; DRW = 1'b1; DADDR = 30'h10; DWDATA = 32'hCAFE_F00D;
    step();
    DREQ = 1'b1; DRW = 1'b0;
    step();
    step();
    chk("wr_rd_back", DRDATA, 32'hCAFE_F00D);

    // Both held continuously: DDDDI repeating.
    i_gnt_seen = 0;
    for (int c = 0; c < 20; c++) begin
      IREQ = 1'b1; IADDR = rand_addr();
      DREQ = 1'b1; DRW = 1'b0; DADDR = rand_addr();
      step();
    end
    chk("starve_i_count", i_gnt_seen, 4);
    IREQ = 1'b0; DREQ = 1'b0;
    step();

    // Reset in the return cycle of an instruction read.
    IREQ = 1'b1; IADDR = 30'h8;
    step();
    IREQ = 1'b1;
    reset_pulse();
    step();

    // Alternating instruction/data reads.
    for (int c = 0; c < 12; c++) begin
      if (c % 2 == 0) begin IREQ = 1'b1; IADDR = rand_addr(); end
      else begin DREQ = 1'b1; DRW = 1'b0; DADDR = rand_addr(); end
      step();
    end

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      if ($urandom_range(0, 299) == 0) reset_pulse();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
